// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing types and the default 640x480@60 timing.
package vga_pkg;
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
  } vga_timing_t;
  localparam vga_timing_t VGA_640_H = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48};
  localparam int VGA_480_V_ACTIVE = 480;
  localparam int VGA_480_V_FP     = 10;
  localparam int VGA_480_V_SYNC   = 2;
  localparam int VGA_480_V_BP     = 33;
endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis; counter plus de/sync decoded from the next count.
module vga_axis_cnt #(
  parameter int ACTIVE = 640,
  parameter int FP = 16,
  parameter int SYNC = 96,
  parameter int BP = 48,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int W = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap,
  output logic         o_de,
  output logic         o_sync
);
  logic [W-1:0] cnt_q, cnt_d;
  int nxt;
  assign o_wrap = i_inc && (cnt_q == W'(TOTAL - 1));
  assign o_cnt = cnt_q;
  always_comb begin
    cnt_d = (i_clr || o_wrap) ? '0 : i_inc ? cnt_q + W'(1) : cnt_q;
    nxt = int'(cnt_d);
    o_de = nxt < ACTIVE;
    o_sync = (nxt >= ACTIVE + FP) && (nxt < ACTIVE + FP + SYNC);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/de/coordinate generator clocked by clk, advanced on
// rising edges of the pixel-rate divider output.
module vga_timing_gen import vga_pkg::*; #(
  parameter int   P_H_ACTIVE = int'(VGA_640_H.h_active),
  parameter int   P_H_FP     = int'(VGA_640_H.h_fp),
  parameter int   P_H_SYNC   = int'(VGA_640_H.h_sync),
  parameter int   P_H_BP     = int'(VGA_640_H.h_bp),
  parameter int   P_V_ACTIVE = VGA_480_V_ACTIVE,
  parameter int   P_V_FP     = VGA_480_V_FP,
  parameter int   P_V_SYNC   = VGA_480_V_SYNC,
  parameter int   P_V_BP     = VGA_480_V_BP,
  parameter logic P_HS_POL   = 1'b0,
  parameter logic P_VS_POL   = 1'b0,
  localparam int H_TOTAL = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP,
  localparam int V_TOTAL = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP,
  localparam int LP_H_W = $clog2(H_TOTAL),
  localparam int LP_V_W = $clog2(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_div,
  input  logic              i_en,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [LP_H_W-1:0] o_hcnt,
  output logic [LP_V_W-1:0] o_vcnt,
  output logic              o_line_start,
  output logic              o_frame_start
);
  logic div_q, pix_en, upd;
  logic h_wrap, v_wrap, h_de, v_de, h_sync, v_sync;
  logic de_q, hs_q, vs_q, ls_q, fs_q;
  assign pix_en = i_div & ~div_q;
  assign upd = pix_en | ~i_en;
  vga_axis_cnt #(.ACTIVE(P_H_ACTIVE), .FP(P_H_FP), .SYNC(P_H_SYNC), .BP(P_H_BP)) u_h (
    .clk(clk), .rst_n(rst_n), .i_inc(pix_en), .i_clr(~i_en),
    .o_cnt(o_hcnt), .o_wrap(h_wrap), .o_de(h_de), .o_sync(h_sync)
  );
  vga_axis_cnt #(.ACTIVE(P_V_ACTIVE), .FP(P_V_FP), .SYNC(P_V_SYNC), .BP(P_V_BP)) u_v (
    .clk(clk), .rst_n(rst_n), .i_inc(pix_en & h_wrap), .i_clr(~i_en),
    .o_cnt(o_vcnt), .o_wrap(v_wrap), .o_de(v_de), .o_sync(v_sync)
  );
  // Outputs reload only when the counters can move, so they always match them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 1'b0;
      de_q  <= 1'b0;
      hs_q  <= ~P_HS_POL;
      vs_q  <= ~P_VS_POL;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= i_div;
      ls_q  <= i_en & h_wrap;
      fs_q  <= i_en & v_wrap;
      if (upd) begin
        de_q <= i_en & h_de & v_de;
        hs_q <= (i_en & h_sync) ? P_HS_POL : ~P_HS_POL;
        vs_q <= (i_en & v_sync) ? P_VS_POL : ~P_VS_POL;
      end
    end
  end
  assign o_de = de_q;
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_line_start = ls_q;
  assign o_frame_start = fs_q;
endmodule
